// File: rtl/adder_result_display.sv
// adder_result_display
// Captures the 5-bit ripple-carry adder result {Cout,S} on a load strobe.
// An iterative subtract-10 FSM converts it to two decimal digits.
// The digits drive a 2-digit, time-multiplexed, common-anode 7-segment display.
// A leading zero on the tens digit is blanked.
module adder_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] S,
  input  logic       Cout,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] an
);

  // A counter width of at least one bit keeps REFRESH_DIV=1 legal.
  localparam int            CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_busy;
  logic [4:0]    r_remainder;
  logic [1:0]    r_tens_work;
  logic [1:0]    r_tens;
  logic [3:0]    r_ones;
  logic [CW-1:0] r_refresh;
  logic          r_digit_sel;

  logic          w_accept;
  logic          w_conv_done;
  logic [3:0]    w_digit;
  logic [6:0]    w_code;

  // A load is honoured only from IDLE, so a load on the edge that clears busy is dropped.
  assign w_accept    = (r_state == IDLE) && load;
  assign w_conv_done = (r_state == CONV) && (r_remainder < 5'd10);
  assign busy        = r_busy;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> CONV on load; CONV -> IDLE once the remainder is below ten.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (load)        w_next_state = CONV;
      CONV: if (w_conv_done) w_next_state = IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  // Conversion datapath: repeatedly subtract ten and count tens.
  // The result is published to the display digits on a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_remainder <= '0;
      r_tens_work <= '0;
      r_tens      <= '0;
      r_ones      <= '0;
    end else if (w_accept) begin
      r_remainder <= {Cout, S};
      r_tens_work <= '0;
      r_busy      <= 1'b1;
    end else if (r_state == CONV) begin
      if (w_conv_done) begin
        r_ones <= r_remainder[3:0];
        r_tens <= r_tens_work;
        r_busy <= 1'b0;
      end else begin
        r_remainder <= r_remainder - 5'd10;
        r_tens_work <= r_tens_work + 2'd1;
      end
    end
  end

  // Free-running refresh counter.
  // It toggles the displayed digit at each terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh   <= '0;
      r_digit_sel <= 1'b0;
    end else if (r_refresh == TERM) begin
      r_refresh   <= '0;
      r_digit_sel <= ~r_digit_sel;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Select the active digit and produce its active-high {g..a} segment pattern.
  always_comb begin
    w_digit = r_digit_sel ? {2'b00, r_tens} : r_ones;
    unique case (w_digit)
      4'd0:    w_code = 7'b0111111;
      4'd1:    w_code = 7'b0000110;
      4'd2:    w_code = 7'b1011011;
      4'd3:    w_code = 7'b1001111;
      4'd4:    w_code = 7'b1100110;
      4'd5:    w_code = 7'b1101101;
      4'd6:    w_code = 7'b1111101;
      4'd7:    w_code = 7'b0000111;
      4'd8:    w_code = 7'b1111111;
      4'd9:    w_code = 7'b1101111;
      default: w_code = 7'b0000000;
    endcase
  end

  // Drive the active-low anodes and segments, blanking a leading zero on the tens digit.
  always_comb begin
    an  = r_digit_sel ? 2'b01 : 2'b10;
    seg = ~w_code;
    if (r_digit_sel && (r_tens == 2'd0)) seg = 7'b1111111;
  end

endmodule

// File: tb/tb_adder_result_display.sv
// Self-checking bench for adder_result_display, with REFRESH_DIV=4.
// A behavioural model tracks the accepted value, the remaining busy cycles and the refresh phase.
// It computes these with plain arithmetic on the loaded value and the count of elapsed cycles.
module tb_adder_result_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] S = '0;
  logic       Cout = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] an;

  int n_tests = 0;
  int n_fail  = 0;

  // Active-low segment images of the digits 0..9.
  logic [6:0] lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  adder_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .S    (S),
    .Cout (Cout),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  // The reference model counts edges since reset and holds the value being converted.
  int m_cnt, m_busy_left, m_tens, m_ones, m_pend_tens, m_pend_ones;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_busy_left = 0; m_tens = 0; m_ones = 0; m_pend_tens = 0; m_pend_ones = 0;
    end else begin
      int v;
      m_cnt++;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_tens = m_pend_tens;
          m_ones = m_pend_ones;
        end
      end else if (load) begin
        v = {27'd0, Cout, S};
        m_busy_left = v / 10 + 1;
        m_pend_tens = v / 10;
        m_pend_ones = v % 10;
      end
    end
  end

  function automatic logic [1:0] exp_an();
    return (((m_cnt / DIV) % 2) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [6:0] exp_seg();
    if (((m_cnt / DIV) % 2) == 1) return (m_tens == 0) ? 7'b1111111 : lut[m_tens];
    return lut[m_ones];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests += 3;
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (an !== 2'b10)        begin n_fail++; $display("FAIL reset_an got=%b want=10", an); end
    if (seg !== 7'b1000000)  begin n_fail++; $display("FAIL reset_seg got=%b want=1000000", seg); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests += 3;
      if (busy !== (m_busy_left > 0)) begin n_fail++; $display("FAIL idle_busy cyc=%0d got=%b", c, busy); end
      if (an !== exp_an())  begin n_fail++; $display("FAIL idle_an cyc=%0d got=%b want=%b", c, an, exp_an()); end
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL idle_seg cyc=%0d got=%b want=%b", c, seg, exp_seg()); end
    end
  endtask

  task automatic test_convert(input int v);
    int bcycles = 0;
    @(negedge clk);
    load = 1'b1;
    {Cout, S} = 5'(v);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (busy === 1'b1) bcycles++;
      n_tests += 3;
      if (busy !== (m_busy_left > 0)) begin n_fail++; $display("FAIL conv%0d_busy cyc=%0d got=%b", v, c, busy); end
      if (an !== exp_an())  begin n_fail++; $display("FAIL conv%0d_an cyc=%0d got=%b want=%b", v, c, an, exp_an()); end
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL conv%0d_seg cyc=%0d got=%b want=%b", v, c, seg, exp_seg()); end
    end
    n_tests++;
    if (bcycles != v / 10 + 1) begin
      n_fail++;
      $display("FAIL conv%0d_busy_len got=%0d want=%0d", v, bcycles, v / 10 + 1);
    end
  endtask

  task automatic test_ignored_load();
    @(negedge clk);
    load = 1'b1; {Cout, S} = 5'd31;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    load = 1'b1; {Cout, S} = 5'd5;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      load = 1'b0;
      n_tests += 3;
      if (busy !== (m_busy_left > 0)) begin n_fail++; $display("FAIL ign_busy cyc=%0d got=%b", c, busy); end
      if (an !== exp_an())  begin n_fail++; $display("FAIL ign_an cyc=%0d got=%b want=%b", c, an, exp_an()); end
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL ign_seg cyc=%0d got=%b want=%b", c, seg, exp_seg()); end
    end
    n_tests++;
    if (m_tens != 3 || m_ones != 1 || busy !== 1'b0 || (an === 2'b10 && seg !== lut[1])) begin
      n_fail++;
      $display("FAIL ign_settle busy=%b an=%b seg=%b want 31 shown", busy, an, seg);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_tests += 3;
      if (busy !== (m_busy_left > 0)) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b", c, busy); end
      if (an !== exp_an())  begin n_fail++; $display("FAIL rnd_an cyc=%0d got=%b want=%b", c, an, exp_an()); end
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL rnd_seg cyc=%0d got=%b want=%b", c, seg, exp_seg()); end
      load = ($urandom_range(0, 2) == 0);
      {Cout, S} = 5'($urandom_range(0, 31));
    end
    load = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load = 1'b1; {Cout, S} = 5'd31;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests += 3;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL arst_busy got=%b want=0", busy); end
    if (an !== 2'b10)       begin n_fail++; $display("FAIL arst_an got=%b want=10", an); end
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL arst_seg got=%b want=1000000", seg); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests += 3;
      if (busy !== (m_busy_left > 0)) begin n_fail++; $display("FAIL arst_post_busy cyc=%0d got=%b", c, busy); end
      if (an !== exp_an())  begin n_fail++; $display("FAIL arst_post_an cyc=%0d got=%b want=%b", c, an, exp_an()); end
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL arst_post_seg cyc=%0d got=%b want=%b", c, seg, exp_seg()); end
    end
  endtask

  initial begin
    test_reset();
    test_convert(9);
    test_convert(31);
    test_ignored_load();
    test_convert(20);
    test_convert(0);
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
